ex_sequencer: RTL and testbench
===============================

# ex_sequencer

Execute-stage controller for the 16-bit MISC-V pipeline. Sits between decode and the execute datapath: it accepts decoded instructions over a valid/ready handshake and sequences single-cycle and multi-cycle ALU operations. It also generates operand-forwarding selects, stalls on load-use hazards, and converts a retiring jump into a PC redirect followed by a fixed-length front-end flush.

## Interface
- REG_AW, 4, register-index width
- MC_LAT, 4, cycles from accept to result for a multi-cycle op (≥2)
- FLUSH_CYCLES, 2, cycles of front-end flush after a redirect (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds an instruction
- id_ready  out  1  execute accepts this cycle
- id_mc  in  1  instruction is multi-cycle
- id_rs1, id_rs2, id_rd  in  REG_AW  source/destination indices
- id_regwrite, id_memread, id_jump  in  1  decoded control bits
- id_target  in  16  jump target (new_pc)
- ex_load  out  1  load EX pipeline registers (= id_valid & id_ready, combinational)
- alu_start  out  1  one-cycle start pulse to the multi-cycle unit
- ex_valid  out  1  EX result valid toward memory stage
- ex_ready  in  1  memory stage accepts EX result
- mem_rd  in  REG_AW; mem_regwrite  in  1  destination of instruction in MEM
- fwd_a, fwd_b  out  2  operand select: 00 regfile, 01 EX result, 10 MEM result
- redirect  out  1  one-cycle PC redirect pulse
- redirect_pc  out  16  target accompanying redirect
- flush  out  1  upstream must discard fetched/decoded instructions

## Operation
- States: IDLE (EX empty), MULTI (mc op in progress), EXEC (result valid), FLUSH.
- Accept = id_valid & id_ready. On accept, latch rd, regwrite, memread, jump, target into EX tag registers.
- id_ready = 1 in IDLE, and in EXEC when ex_ready=1 and the EX tag is not a jump. It is 0 in MULTI and 0 during load-use stall. It is 1 in FLUSH, where accepts are dropped and nothing is latched.
- Load-use stall: EX tag has memread=1, regwrite=1, rd≠0, and rd equals id_rs1 or id_rs2. While this holds, id_ready=0.
- IDLE --accept, !id_mc--> EXEC; IDLE --accept, id_mc--> MULTI; counter loads MC_LAT-1; alu_start=1 in the first MULTI cycle.
- MULTI: counter decrements each cycle; at 1 → EXEC.
- EXEC with ex_ready=0: hold and keep ex_valid=1 (no tag change).
- EXEC with ex_ready=1: retire. If the tag is a jump → FLUSH with redirect pulse. Else, accept next in the same cycle (→ EXEC/MULTI), or → IDLE if none is accepted.
- FLUSH: flush=1 for FLUSH_CYCLES cycles, then IDLE.
- Forwarding, per operand: choose 01 if EX tag regwrite=1, rd≠0, rd==rs, and the EX tag is occupied (EXEC or MULTI, non-load). Otherwise choose 10 if mem_regwrite=1, mem_rd≠0, and mem_rd==rs. Otherwise 00. EX has priority over MEM.

## Timing
- Reset values: id_ready=0 while reset is asserted; ex_valid=0, alu_start=0, redirect=0, redirect_pc=0, flush=0, fwd_a=fwd_b=00, state IDLE, counter 0, tags cleared.
- Single-cycle op: ex_valid=1 the cycle after accept.
- Multi-cycle op: ex_valid=1 exactly MC_LAT cycles after accept.
- Back-to-back single-cycle ops: 1 per cycle when ex_ready=1.
- redirect and redirect_pc are registered: redirect is high the cycle after the jump retires. flush is high in that cycle and for FLUSH_CYCLES total.
- fwd_a/fwd_b and id_ready are combinational from the current tags and id_* inputs.
- Reset asserted mid-MULTI or mid-FLUSH aborts immediately to reset values; no redirect is emitted.

## Configuration
- EX_SEQ_FWD_EN defined: forwarding as above.
- EX_SEQ_FWD_EN undefined: fwd_a=fwd_b=00 always. Any RAW match of id_rs1/id_rs2 against the EX tag or mem_rd (regwrite=1, rd≠0) stalls id_ready=0.

## Test plan
- Reset low mid-stream, then high → all outputs at reset values; first accept with id_mc=0 gives ex_valid=1 one cycle later.
- id_mc=1 accept at cycle 0, ex_ready=1 → alu_start at cycle 1, ex_valid at cycle 4 (MC_LAT=4), id_ready=0 in cycles 1–3.
- Load to r3 in EX, next instruction rs1=3 → id_ready=0 until the load retires. Next instruction rs2=3 after a non-load write to r3 → fwd_b=01. With EX_SEQ_FWD_EN undefined → stall instead.
- Jump with target 0x1234 held with ex_ready=0 for 2 cycles, then released → redirect=1 with redirect_pc=0x1234 one cycle after release. flush=1 for 2 cycles; id_valid accepts during flush do not produce ex_valid.
- EX writes r5 and MEM writes r5 simultaneously, id_rs1=5 → fwd_a=01. With rd=0 → fwd_a=00.
- ex_ready=0 for 3 cycles in EXEC → ex_valid stays 1, id_ready=0, the tag is unchanged.

Source files
------------

// File: rtl/ex_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ex_sequencer
// Brief   : Execute-stage controller for the 16-bit MISC-V pipeline: issue
//           handshake, multi-cycle sequencing, forwarding selects, load-use
//           stall and jump redirect/flush. Define EX_SEQ_FWD_EN to enable
//           operand forwarding; otherwise every RAW hazard stalls issue.
// Rev     : 1.0 - initial release
// ============================================================================
module ex_sequencer #(
    parameter int REG_AW       = 4,
    parameter int MC_LAT       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic              id_mc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_jump,
    input  logic [15:0]       id_target,
    output logic              ex_load,
    output logic              alu_start,
    output logic              ex_valid,
    input  logic              ex_ready,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              redirect,
    output logic [15:0]       redirect_pc,
    output logic              flush
);

    localparam int c_MC_W = $clog2(MC_LAT + 1);
    localparam int c_FL_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [c_MC_W-1:0] c_MC_LOAD = c_MC_W'(MC_LAT - 1);
    localparam logic [c_MC_W-1:0] c_MC_ONE  = c_MC_W'(1);
    localparam logic [c_FL_W-1:0] c_FL_LOAD = c_FL_W'(FLUSH_CYCLES - 1);
    localparam logic [c_FL_W-1:0] c_FL_ONE  = c_FL_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_MULTI = 2'd1;
    localparam logic [1:0] c_ST_EXEC  = 2'd2;
    localparam logic [1:0] c_ST_FLUSH = 2'd3;

    localparam logic [1:0] c_FWD_RF  = 2'b00;
    localparam logic [1:0] c_FWD_EX  = 2'b01;
    localparam logic [1:0] c_FWD_MEM = 2'b10;

    logic [1:0]        r_state;
    logic [c_MC_W-1:0] r_mc_cnt;
    logic [c_FL_W-1:0] r_fl_cnt;
    logic [REG_AW-1:0] r_tag_rd;
    logic              r_tag_regwrite;
    logic              r_tag_memread;
    logic              r_tag_jump;
    logic [15:0]       r_tag_target;
    logic              r_alu_start;
    logic              r_redirect;
    logic [15:0]       r_redirect_pc;

    logic [1:0]        w_state_nx;
    logic [c_MC_W-1:0] w_mc_cnt_nx;
    logic [c_FL_W-1:0] w_fl_cnt_nx;
    logic              w_alu_start_nx;
    logic              w_redirect_nx;
    logic [15:0]       w_redirect_pc_nx;

    logic              w_tag_occ;
    logic              w_ex_wr;
    logic              w_ex_hit_a;
    logic              w_ex_hit_b;
    logic              w_mem_wr;
    logic              w_mem_hit_a;
    logic              w_mem_hit_b;
    logic              w_load_use;
    logic              w_stall;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;
    logic              w_id_ready;
    logic              w_accept;
    logic              w_take;

    // Tags only describe a live instruction while EX is occupied; in IDLE
    // they are stale leftovers of the last retired op.
    assign w_tag_occ   = (r_state == c_ST_EXEC) || (r_state == c_ST_MULTI);
    assign w_ex_wr     = w_tag_occ && r_tag_regwrite && (r_tag_rd != '0);
    assign w_ex_hit_a  = w_ex_wr && (r_tag_rd == id_rs1);
    assign w_ex_hit_b  = w_ex_wr && (r_tag_rd == id_rs2);
    assign w_mem_wr    = mem_regwrite && (mem_rd != '0);
    assign w_mem_hit_a = w_mem_wr && (mem_rd == id_rs1);
    assign w_mem_hit_b = w_mem_wr && (mem_rd == id_rs2);
    assign w_load_use  = r_tag_memread && (w_ex_hit_a || w_ex_hit_b);

`ifdef EX_SEQ_FWD_EN
    always_comb begin
        w_stall = w_load_use;
        w_fwd_a = c_FWD_RF;
        w_fwd_b = c_FWD_RF;
        if (w_ex_hit_a && !r_tag_memread) begin
            w_fwd_a = c_FWD_EX;
        end else if (w_mem_hit_a) begin
            w_fwd_a = c_FWD_MEM;
        end
        if (w_ex_hit_b && !r_tag_memread) begin
            w_fwd_b = c_FWD_EX;
        end else if (w_mem_hit_b) begin
            w_fwd_b = c_FWD_MEM;
        end
    end
`else
    always_comb begin
        w_stall = w_load_use || w_ex_hit_a || w_ex_hit_b || w_mem_hit_a || w_mem_hit_b;
        w_fwd_a = c_FWD_RF;
        w_fwd_b = c_FWD_RF;
    end
`endif

    always_comb begin
        w_id_ready = 1'b0;
        case (r_state)
            c_ST_IDLE:  w_id_ready = !w_stall;
            c_ST_EXEC:  w_id_ready = ex_ready && !r_tag_jump && !w_stall;
            c_ST_FLUSH: w_id_ready = 1'b1;
            default:    w_id_ready = 1'b0;
        endcase
        if (!reset) begin
            w_id_ready = 1'b0;
        end
    end

    assign w_accept = id_valid && w_id_ready;
    // Handshakes completed during FLUSH are swallowed here.
    assign w_take   = w_accept && (r_state != c_ST_FLUSH);

    always_comb begin
        w_state_nx       = r_state;
        w_mc_cnt_nx      = r_mc_cnt;
        w_fl_cnt_nx      = r_fl_cnt;
        w_alu_start_nx   = 1'b0;
        w_redirect_nx    = 1'b0;
        w_redirect_pc_nx = r_redirect_pc;
        case (r_state)
            c_ST_IDLE: begin
                if (w_take) begin
                    if (id_mc) begin
                        w_state_nx     = c_ST_MULTI;
                        w_mc_cnt_nx    = c_MC_LOAD;
                        w_alu_start_nx = 1'b1;
                    end else begin
                        w_state_nx = c_ST_EXEC;
                    end
                end
            end
            c_ST_MULTI: begin
                w_mc_cnt_nx = r_mc_cnt - c_MC_ONE;
                if (r_mc_cnt <= c_MC_ONE) begin
                    w_state_nx = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                if (ex_ready) begin
                    if (r_tag_jump) begin
                        w_state_nx       = c_ST_FLUSH;
                        w_fl_cnt_nx      = c_FL_LOAD;
                        w_redirect_nx    = 1'b1;
                        w_redirect_pc_nx = r_tag_target;
                    end else if (w_take) begin
                        if (id_mc) begin
                            w_state_nx     = c_ST_MULTI;
                            w_mc_cnt_nx    = c_MC_LOAD;
                            w_alu_start_nx = 1'b1;
                        end else begin
                            w_state_nx = c_ST_EXEC;
                        end
                    end else begin
                        w_state_nx = c_ST_IDLE;
                    end
                end
            end
            default: begin
                if (r_fl_cnt == '0) begin
                    w_state_nx = c_ST_IDLE;
                end else begin
                    w_fl_cnt_nx = r_fl_cnt - c_FL_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= c_ST_IDLE;
            r_mc_cnt       <= '0;
            r_fl_cnt       <= '0;
            r_tag_rd       <= '0;
            r_tag_regwrite <= 1'b0;
            r_tag_memread  <= 1'b0;
            r_tag_jump     <= 1'b0;
            r_tag_target   <= '0;
            r_alu_start    <= 1'b0;
            r_redirect     <= 1'b0;
            r_redirect_pc  <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_mc_cnt      <= w_mc_cnt_nx;
            r_fl_cnt      <= w_fl_cnt_nx;
            r_alu_start   <= w_alu_start_nx;
            r_redirect    <= w_redirect_nx;
            r_redirect_pc <= w_redirect_pc_nx;
            if (w_take) begin
                r_tag_rd       <= id_rd;
                r_tag_regwrite <= id_regwrite;
                r_tag_memread  <= id_memread;
                r_tag_jump     <= id_jump;
                r_tag_target   <= id_target;
            end
        end
    end

    assign id_ready    = w_id_ready;
    assign ex_load     = w_accept;
    assign alu_start   = r_alu_start;
    assign ex_valid    = (r_state == c_ST_EXEC);
    assign fwd_a       = w_fwd_a;
    assign fwd_b       = w_fwd_b;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign flush       = (r_state == c_ST_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_ex_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_sequencer
// Brief   : Self-checking bench for ex_sequencer (vector table plus directed
//           jump, stall and reset sequences); tracks EX_SEQ_FWD_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_ex_sequencer;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic        id_mc;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic [3:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_jump;
    logic [15:0] id_target;
    logic        ex_load;
    logic        alu_start;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  mem_rd;
    logic        mem_regwrite;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        flush;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef EX_SEQ_FWD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    ex_sequencer #(.REG_AW(4), .MC_LAT(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready), .id_mc(id_mc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_jump(id_jump), .id_target(id_target),
        .ex_load(ex_load), .alu_start(alu_start),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic       mc;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic       rw;
        logic       mr;
        logic       exr;
        logic [3:0] mrd;
        logic       mrw;
        logic       rdy;   // id_ready with forwarding enabled
        logic [1:0] fa;
        logic [1:0] fb;
        logic       ev;    // ex_valid after the edge
        logic       ast;   // alu_start after the edge
    } vec_t;

    vec_t vt [15];

    function automatic vec_t mk(input logic vld, input logic mc,
                                input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                                input logic rw, input logic mr, input logic exr,
                                input logic [3:0] mrd, input logic mrw,
                                input logic rdy, input logic [1:0] fa, input logic [1:0] fb,
                                input logic ev, input logic ast);
        vec_t v;
        v.vld = vld; v.mc = mc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.rw = rw; v.mr = mr; v.exr = exr; v.mrd = mrd; v.mrw = mrw;
        v.rdy = rdy; v.fa = fa; v.fb = fb; v.ev = ev; v.ast = ast;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_in();
        id_valid = 0; id_mc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_regwrite = 0; id_memread = 0; id_jump = 0; id_target = 0;
        ex_ready = 1; mem_rd = 0; mem_regwrite = 0;
    endtask

    logic       e_rdy;
    logic [1:0] e_fa;
    logic [1:0] e_fb;

    initial begin
        // rows: vld mc rs1 rs2 rd rw mr exr mrd mrw | rdy fa fb | ev ast
        vt[0]  = mk(1,0, 1,2,3, 1,0,1, 0,0, 1,0,0, 1,0); // IDLE accept single
        vt[1]  = mk(1,0, 4,5,6, 1,0,1, 0,0, 1,0,0, 1,0); // back-to-back
        vt[2]  = mk(0,0, 6,7,0, 0,0,0, 7,1, 0,1,2, 1,0); // EX on a, MEM on b, held
        vt[3]  = mk(0,0, 6,6,0, 0,0,0, 6,1, 0,1,1, 1,0); // EX beats MEM
        vt[4]  = mk(0,0, 0,0,0, 0,0,1, 0,1, 1,0,0, 0,0); // r0 never forwards; retire
        vt[5]  = mk(0,0, 6,9,0, 0,0,1, 9,1, 1,0,2, 0,0); // stale tag ignored in IDLE
        vt[6]  = mk(1,1, 1,2,8, 1,0,1, 0,0, 1,0,0, 0,1); // multi-cycle accept
        vt[7]  = mk(1,0, 8,8,1, 1,0,1, 0,0, 0,1,1, 0,0); // MULTI cycle 1
        vt[8]  = mk(0,0, 0,0,0, 0,0,1, 0,0, 0,0,0, 0,0); // MULTI cycle 2
        vt[9]  = mk(0,0, 0,0,0, 0,0,1, 0,0, 0,0,0, 1,0); // MULTI cycle 3 -> EXEC
        vt[10] = mk(1,0, 2,3,3, 1,1,1, 0,0, 1,0,0, 1,0); // load to r3
        vt[11] = mk(1,0, 3,0,4, 1,0,0, 0,0, 0,0,0, 1,0); // load-use, MEM busy
        vt[12] = mk(1,0, 3,0,4, 1,0,1, 0,0, 0,0,0, 0,0); // load-use while retiring
        vt[13] = mk(1,0, 3,0,4, 1,0,1, 0,0, 1,0,0, 1,0); // dependent issues from IDLE
        vt[14] = mk(0,0, 4,0,0, 0,0,1, 0,0, 1,1,0, 0,0); // forward from EX r4

        zero_in();
        reset = 1'b0;
        id_valid = 1'b1;
        repeat (2) cyc();
        chk("rst.id_ready", 32'(id_ready), 0);
        chk("rst.ex_load", 32'(ex_load), 0);
        chk("rst.ex_valid", 32'(ex_valid), 0);
        chk("rst.alu_start", 32'(alu_start), 0);
        chk("rst.redirect", 32'(redirect), 0);
        chk("rst.redirect_pc", 32'(redirect_pc), 0);
        chk("rst.flush", 32'(flush), 0);
        chk("rst.fwd_a", 32'(fwd_a), 0);
        chk("rst.fwd_b", 32'(fwd_b), 0);
        reset = 1'b1;
        zero_in();

        for (int i = 0; i < 15; i++) begin
            id_valid = vt[i].vld; id_mc = vt[i].mc;
            id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; id_rd = vt[i].rd;
            id_regwrite = vt[i].rw; id_memread = vt[i].mr;
            ex_ready = vt[i].exr; mem_rd = vt[i].mrd; mem_regwrite = vt[i].mrw;
            e_rdy = vt[i].rdy; e_fa = vt[i].fa; e_fb = vt[i].fb;
            if (!c_FWD) begin
                if (e_fa != 2'b00 || e_fb != 2'b00) e_rdy = 1'b0;
                e_fa = 2'b00;
                e_fb = 2'b00;
            end
            #1;
            chk($sformatf("v%0d.id_ready", i), 32'(id_ready), 32'(e_rdy));
            chk($sformatf("v%0d.ex_load", i), 32'(ex_load), 32'(vt[i].vld & e_rdy));
            chk($sformatf("v%0d.fwd_a", i), 32'(fwd_a), 32'(e_fa));
            chk($sformatf("v%0d.fwd_b", i), 32'(fwd_b), 32'(e_fb));
            cyc();
            chk($sformatf("v%0d.ex_valid", i), 32'(ex_valid), 32'(vt[i].ev));
            chk($sformatf("v%0d.alu_start", i), 32'(alu_start), 32'(vt[i].ast));
        end

        // EX holds r5 for 3 cycles while MEM also writes r5
        zero_in();
        id_valid = 1; id_rd = 5; id_regwrite = 1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            id_valid = 1; id_rs1 = 5; id_rd = 9; ex_ready = 0;
            mem_rd = 5; mem_regwrite = 1;
            #1;
            chk($sformatf("hold%0d.id_ready", k), 32'(id_ready), 0);
            chk($sformatf("hold%0d.fwd_a", k), 32'(fwd_a), c_FWD ? 1 : 0);
            cyc();
            chk($sformatf("hold%0d.ex_valid", k), 32'(ex_valid), 1);
        end
        id_valid = 0; ex_ready = 1;
        #1;
        chk("hold.tag_fwd_a", 32'(fwd_a), c_FWD ? 1 : 0);
        chk("hold.release_ready", 32'(id_ready), c_FWD ? 1 : 0);
        cyc();
        chk("hold.retired", 32'(ex_valid), 0);

        // rd=0 in EX and MEM never forwards or stalls
        zero_in();
        id_valid = 1; id_rd = 0; id_regwrite = 1;
        cyc();
        id_valid = 0; mem_rd = 0; mem_regwrite = 1;
        #1;
        chk("r0.fwd_a", 32'(fwd_a), 0);
        chk("r0.id_ready", 32'(id_ready), 1);
        cyc();

        // jump held 2 cycles, then redirect + 2-cycle flush
        zero_in();
        id_valid = 1; id_jump = 1; id_target = 16'h1234; ex_ready = 0;
        cyc();
        zero_in();
        ex_ready = 0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk($sformatf("jhold%0d.ex_valid", k), 32'(ex_valid), 1);
            chk($sformatf("jhold%0d.redirect", k), 32'(redirect), 0);
        end
        ex_ready = 1; id_valid = 1; id_rd = 7; id_regwrite = 1;
        #1;
        chk("jmp.id_ready", 32'(id_ready), 0);
        cyc();
        chk("jmp.redirect", 32'(redirect), 1);
        chk("jmp.redirect_pc", 32'(redirect_pc), 32'h1234);
        chk("jmp.flush1", 32'(flush), 1);
        chk("jmp.ex_valid1", 32'(ex_valid), 0);
        chk("jmp.flush_ready", 32'(id_ready), 1);
        cyc();
        chk("jmp.redirect_off", 32'(redirect), 0);
        chk("jmp.flush2", 32'(flush), 1);
        chk("jmp.ex_valid2", 32'(ex_valid), 0);
        cyc();
        chk("jmp.flush_done", 32'(flush), 0);
        chk("jmp.dropped", 32'(ex_valid), 0);
        zero_in();
        cyc();

        // reset mid-MULTI
        id_valid = 1; id_mc = 1; id_rd = 2; id_regwrite = 1;
        cyc();
        chk("rmc.alu_start", 32'(alu_start), 1);
        id_mc = 0; id_rs1 = 2;
        #2;
        reset = 1'b0;
        #1;
        chk("rmc.alu_start0", 32'(alu_start), 0);
        chk("rmc.id_ready", 32'(id_ready), 0);
        chk("rmc.redirect_pc", 32'(redirect_pc), 0);
        chk("rmc.fwd_a", 32'(fwd_a), 0);
        cyc();
        chk("rmc.ex_valid", 32'(ex_valid), 0);
        reset = 1'b1;
        zero_in();
        id_valid = 1; id_rd = 1;
        #1;
        chk("rmc.first_ready", 32'(id_ready), 1);
        cyc();
        chk("rmc.first_ex_valid", 32'(ex_valid), 1);
        chk("rmc.first_alu_start", 32'(alu_start), 0);
        zero_in();
        cyc();

        // reset mid-FLUSH
        id_valid = 1; id_jump = 1; id_target = 16'hBEEF;
        cyc();
        zero_in();
        cyc();
        chk("rfl.flush", 32'(flush), 1);
        chk("rfl.redirect_pc", 32'(redirect_pc), 32'hBEEF);
        #2;
        reset = 1'b0;
        #1;
        chk("rfl.flush0", 32'(flush), 0);
        chk("rfl.redirect0", 32'(redirect), 0);
        chk("rfl.redirect_pc0", 32'(redirect_pc), 0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("rfl.after_redirect", 32'(redirect), 0);
        chk("rfl.after_flush", 32'(flush), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
